// File: rtl/ddrx_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ddrx_pkg
// Description : Shared definitions for the DDR3 initialisation sequencer:
//               DFI command opcodes {cs_n,ras_n,cas_n,we_n}, the sequencer
//               state encoding and the mode-register-to-bank-index mapping.
// Revision    : 1.0 - initial release
//==============================================================================
package ddrx_pkg;

    // Command opcodes, bit order {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_ZQCL  = 4'b0110;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PHY_INIT  = 4'd1,
        ST_RST_HOLD  = 4'd2,
        ST_CKE_WAIT  = 4'd3,
        ST_XPR       = 4'd4,
        ST_MRS2      = 4'd5,
        ST_MRS3      = 4'd6,
        ST_MRS1      = 4'd7,
        ST_MRS0      = 4'd8,
        ST_ZQCL      = 4'd9,
        ST_DONE      = 4'd10
    } init_state_t;

    // Mode register select; the value is the bank address used for MRS
    typedef enum logic [1:0] {
        MR_SEL_0 = 2'd0,
        MR_SEL_1 = 2'd1,
        MR_SEL_2 = 2'd2,
        MR_SEL_3 = 2'd3
    } mr_sel_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/init_timer.sv
`default_nettype none
//==============================================================================
// Module      : init_timer
// Description : Load-and-count-down interval timer. Loading N (0 treated as 1)
//               makes o_expired assert on the N-th cycle after the load edge,
//               so a state that loads on entry lasts exactly N cycles.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_load        - load i_value on this edge
//               i_value       - interval in cycles
//               o_expired     - count has reached 1 (last cycle of interval)
// Revision    : 1.0 - initial release
//==============================================================================
module init_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= (i_value == '0) ? WIDTH'(1) : i_value;
        end else if (r_count > WIDTH'(1)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/ddr3_init_seq.sv
`default_nettype none
//==============================================================================
// Module      : ddr3_init_seq
// Description : DDR3 power-up initialisation sequencer on the DFI control bus.
//               DFI init handshake, reset_n / CKE timing, MRS to MR2, MR3,
//               MR1, MR0, then ZQCL, then sticky init_done.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               dfi_init_start      - init request to PHY (high from PHY_INIT)
//               dfi_init_complete   - PHY init done
//               dfi_reset_n/dfi_cke - per-phase, all phases equal
//               dfi_cs_n..dfi_we_n  - per-phase command, bit = phase
//               dfi_address/bank    - packed, bit index = field_bit*RATIO+phase
//               init_busy/init_done - sequence status
// Revision    : 1.0 - initial release
//==============================================================================
module ddr3_init_seq
    import ddrx_pkg::*;
#(
    parameter int          C_DFI_FREQ_RATIO = 2,
    parameter int          C_DFI_ADDR_WIDTH = 16,
    parameter int          C_DFI_BANK_WIDTH = 3,
    parameter int          C_T_RESET        = 40000,
    parameter int          C_T_CKE          = 100000,
    parameter int          C_T_XPR          = 64,
    parameter int          C_T_MRD          = 4,
    parameter int          C_T_MOD          = 12,
    parameter int          C_T_ZQINIT       = 512,
    parameter logic [12:0] C_MR0            = 13'h0520,
    parameter logic [12:0] C_MR1            = 13'h0044,
    parameter logic [12:0] C_MR2            = 13'h0008,
    parameter logic [12:0] C_MR3            = 13'h0000
) (
    input  logic                                     clk,
    input  logic                                     rst,
    output logic                                     dfi_init_start,
    input  logic                                     dfi_init_complete,
    output logic [C_DFI_FREQ_RATIO-1:0]              dfi_reset_n,
    output logic [C_DFI_FREQ_RATIO-1:0]              dfi_cke,
    output logic [C_DFI_FREQ_RATIO-1:0]              dfi_cs_n,
    output logic [C_DFI_FREQ_RATIO-1:0]              dfi_ras_n,
    output logic [C_DFI_FREQ_RATIO-1:0]              dfi_cas_n,
    output logic [C_DFI_FREQ_RATIO-1:0]              dfi_we_n,
    output logic [C_DFI_ADDR_WIDTH*C_DFI_FREQ_RATIO-1:0] dfi_address,
    output logic [C_DFI_BANK_WIDTH*C_DFI_FREQ_RATIO-1:0] dfi_bank,
    output logic                                     init_busy,
    output logic                                     init_done
);

    localparam int R  = C_DFI_FREQ_RATIO;
    localparam int AW = C_DFI_ADDR_WIDTH;
    localparam int BW = C_DFI_BANK_WIDTH;

    localparam int T_MAX = max_of(max_of(max_of(C_T_RESET, C_T_CKE), max_of(C_T_XPR, C_T_MRD)),
                                  max_of(max_of(C_T_MOD, C_T_ZQINIT), 1));
    // +1 so a maximum that is an exact power of two still fits
    localparam int TW = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] LD_RESET  = TW'(C_T_RESET);
    localparam logic [TW-1:0] LD_CKE    = TW'(C_T_CKE);
    localparam logic [TW-1:0] LD_XPR    = TW'(C_T_XPR);
    localparam logic [TW-1:0] LD_MRD    = TW'(C_T_MRD);
    localparam logic [TW-1:0] LD_MOD    = TW'(C_T_MOD);
    localparam logic [TW-1:0] LD_ZQINIT = TW'(C_T_ZQINIT);

    init_state_t       r_state;
    init_state_t       w_next;
    logic              w_load;
    logic [TW-1:0]     w_load_val;
    logic              w_expired;

    init_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_value   (w_load_val),
        .o_expired (w_expired)
    );

    // Next state and timer load; each timed state loads its duration on entry
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE:     w_next = ST_PHY_INIT;
            ST_PHY_INIT: if (dfi_init_complete) begin
                w_next = ST_RST_HOLD; w_load = 1'b1; w_load_val = LD_RESET;
            end
            ST_RST_HOLD: if (w_expired) begin
                w_next = ST_CKE_WAIT; w_load = 1'b1; w_load_val = LD_CKE;
            end
            ST_CKE_WAIT: if (w_expired) begin
                w_next = ST_XPR; w_load = 1'b1; w_load_val = LD_XPR;
            end
            ST_XPR:      if (w_expired) begin
                w_next = ST_MRS2; w_load = 1'b1; w_load_val = LD_MRD;
            end
            ST_MRS2:     if (w_expired) begin
                w_next = ST_MRS3; w_load = 1'b1; w_load_val = LD_MRD;
            end
            ST_MRS3:     if (w_expired) begin
                w_next = ST_MRS1; w_load = 1'b1; w_load_val = LD_MRD;
            end
            ST_MRS1:     if (w_expired) begin
                w_next = ST_MRS0; w_load = 1'b1; w_load_val = LD_MOD;
            end
            ST_MRS0:     if (w_expired) begin
                w_next = ST_ZQCL; w_load = 1'b1; w_load_val = LD_ZQINIT;
            end
            ST_ZQCL:     if (w_expired) w_next = ST_DONE;
            ST_DONE:     w_next = ST_DONE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the registered state.
    logic                w_start_v;
    logic                w_rst_n_v;
    logic                w_cke_v;
    logic [3:0]          w_base;
    logic [3:0]          w_op0;
    logic [AW-1:0]       w_addr0;
    logic [BW-1:0]       w_bank0;
    logic [R-1:0]        w_cs_n, w_ras_n, w_cas_n, w_we_n;
    logic [AW*R-1:0]     w_address;
    logic [BW*R-1:0]     w_bank;

    always_comb begin
        w_start_v = (w_next != ST_IDLE);
        w_rst_n_v = w_next inside {ST_CKE_WAIT, ST_XPR, ST_MRS2, ST_MRS3,
                                   ST_MRS1, ST_MRS0, ST_ZQCL, ST_DONE};
        w_cke_v   = w_next inside {ST_XPR, ST_MRS2, ST_MRS3, ST_MRS1,
                                   ST_MRS0, ST_ZQCL, ST_DONE};
        w_base    = w_cke_v ? CMD_NOP : CMD_DESEL;
        w_op0     = w_base;
        w_addr0   = '0;
        w_bank0   = '0;
        // A command state issues only on its first cycle (the entry edge)
        if (w_next != r_state) begin
            case (w_next)
                ST_MRS2: begin w_op0 = CMD_MRS; w_addr0[12:0] = C_MR2; w_bank0 = BW'(MR_SEL_2); end
                ST_MRS3: begin w_op0 = CMD_MRS; w_addr0[12:0] = C_MR3; w_bank0 = BW'(MR_SEL_3); end
                ST_MRS1: begin w_op0 = CMD_MRS; w_addr0[12:0] = C_MR1; w_bank0 = BW'(MR_SEL_1); end
                ST_MRS0: begin w_op0 = CMD_MRS; w_addr0[12:0] = C_MR0; w_bank0 = BW'(MR_SEL_0); end
                ST_ZQCL: begin w_op0 = CMD_ZQCL; w_addr0[10] = 1'b1; end
                default: ;
            endcase
        end
        w_cs_n    = {R{w_base[3]}};
        w_ras_n   = {R{w_base[2]}};
        w_cas_n   = {R{w_base[1]}};
        w_we_n    = {R{w_base[0]}};
        w_cs_n[0]  = w_op0[3];
        w_ras_n[0] = w_op0[2];
        w_cas_n[0] = w_op0[1];
        w_we_n[0]  = w_op0[0];
        w_address = '0;
        w_bank    = '0;
        for (int a = 0; a < AW; a++) w_address[a*R] = w_addr0[a];
        for (int b = 0; b < BW; b++) w_bank[b*R]    = w_bank0[b];
    end

    logic              r_start;
    logic [R-1:0]      r_reset_n, r_cke, r_cs_n, r_ras_n, r_cas_n, r_we_n;
    logic [AW*R-1:0]   r_address;
    logic [BW*R-1:0]   r_bank;
    logic              r_busy, r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_start   <= 1'b0;
            r_reset_n <= '0;
            r_cke     <= '0;
            r_cs_n    <= '1;
            r_ras_n   <= '1;
            r_cas_n   <= '1;
            r_we_n    <= '1;
            r_address <= '0;
            r_bank    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start   <= w_start_v;
            r_reset_n <= {R{w_rst_n_v}};
            r_cke     <= {R{w_cke_v}};
            r_cs_n    <= w_cs_n;
            r_ras_n   <= w_ras_n;
            r_cas_n   <= w_cas_n;
            r_we_n    <= w_we_n;
            r_address <= w_address;
            r_bank    <= w_bank;
            r_busy    <= w_start_v && (w_next != ST_DONE);
            r_done    <= (w_next == ST_DONE);
        end
    end

    assign dfi_init_start = r_start;
    assign dfi_reset_n    = r_reset_n;
    assign dfi_cke        = r_cke;
    assign dfi_cs_n       = r_cs_n;
    assign dfi_ras_n      = r_ras_n;
    assign dfi_cas_n      = r_cas_n;
    assign dfi_we_n       = r_we_n;
    assign dfi_address    = r_address;
    assign dfi_bank       = r_bank;
    assign init_busy      = r_busy;
    assign init_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_init_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_ddr3_init_seq
// Description : Directed bench for ddr3_init_seq with shortened timings
//               (tRESET=8, tCKE=5, tXPR=3, tMRD=4, tMOD=6, tZQINIT=10) plus a
//               second instance with tMRD=0 sharing the same stimulus.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ddr3_init_seq;

    localparam logic [3:0] OP_DESEL = 4'b1111;
    localparam logic [3:0] OP_NOP   = 4'b0111;
    localparam logic [3:0] OP_MRS   = 4'b0000;
    localparam logic [3:0] OP_ZQCL  = 4'b0110;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmp;

    logic        start, busy, done;
    logic [1:0]  reset_n, cke, cs_n, ras_n, cas_n, we_n;
    logic [31:0] addr;
    logic [5:0]  bank;

    logic        b_start, b_busy, b_done;
    logic [1:0]  b_reset_n, b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n;
    logic [31:0] b_addr;
    logic [5:0]  b_bank;

    wire  [7:0]  cmd   = {cs_n[1], cs_n[0], ras_n[1], ras_n[0], cas_n[1], cas_n[0], we_n[1], we_n[0]};
    wire  [7:0]  b_cmd = {b_cs_n[1], b_cs_n[0], b_ras_n[1], b_ras_n[0], b_cas_n[1], b_cas_n[0], b_we_n[1], b_we_n[0]};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ddr3_init_seq #(
        .C_T_RESET (8), .C_T_CKE (5), .C_T_XPR (3),
        .C_T_MRD (4), .C_T_MOD (6), .C_T_ZQINIT (10)
    ) dut (
        .clk (clk), .rst (rst),
        .dfi_init_start (start), .dfi_init_complete (cmp),
        .dfi_reset_n (reset_n), .dfi_cke (cke),
        .dfi_cs_n (cs_n), .dfi_ras_n (ras_n), .dfi_cas_n (cas_n), .dfi_we_n (we_n),
        .dfi_address (addr), .dfi_bank (bank),
        .init_busy (busy), .init_done (done)
    );

    ddr3_init_seq #(
        .C_T_RESET (8), .C_T_CKE (5), .C_T_XPR (3),
        .C_T_MRD (0), .C_T_MOD (6), .C_T_ZQINIT (10)
    ) dut_b (
        .clk (clk), .rst (rst),
        .dfi_init_start (b_start), .dfi_init_complete (cmp),
        .dfi_reset_n (b_reset_n), .dfi_cke (b_cke),
        .dfi_cs_n (b_cs_n), .dfi_ras_n (b_ras_n), .dfi_cas_n (b_cas_n), .dfi_we_n (b_we_n),
        .dfi_address (b_addr), .dfi_bank (b_bank),
        .init_busy (b_busy), .init_done (b_done)
    );

    // Expected packed views: phase 0 carries the value, phase 1 carries op1 / zero
    function automatic logic [7:0] cmd_pk(input logic [3:0] op0, input logic [3:0] op1);
        return {op1[3], op0[3], op1[2], op0[2], op1[1], op0[1], op1[0], op0[0]};
    endfunction

    function automatic logic [31:0] addr_pk(input logic [15:0] a0);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[2*i] = a0[i];
        return r;
    endfunction

    function automatic logic [5:0] bank_pk(input logic [2:0] b0);
        return {1'b0, b0[2], 1'b0, b0[1], 1'b0, b0[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start"},   start,   1'b0);
        chk({tag, "_reset_n"}, reset_n, 2'b00);
        chk({tag, "_cke"},     cke,     2'b00);
        chk({tag, "_cmd"},     cmd,     cmd_pk(OP_DESEL, OP_DESEL));
        chk({tag, "_addr"},    addr,    32'h0);
        chk({tag, "_bank"},    bank,    6'h0);
        chk({tag, "_busy"},    busy,    1'b0);
        chk({tag, "_done"},    done,    1'b0);
    endtask

    task automatic nop_chk(input string tag);
        chk({tag, "_cmd"},  cmd,  cmd_pk(OP_NOP, OP_NOP));
        chk({tag, "_addr"}, addr, 32'h0);
        chk({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic nop_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            nop_chk(tag);
        end
    endtask

    task automatic issue_chk(input string tag, input logic [3:0] op,
                             input logic [15:0] a0, input logic [2:0] b0);
        tick();
        chk({tag, "_cmd"},  cmd,  cmd_pk(op, OP_NOP));
        chk({tag, "_addr"}, addr, addr_pk(a0));
        chk({tag, "_bank"}, bank, bank_pk(b0));
        chk({tag, "_cke"},  cke,  2'b11);
    endtask

    // Starts with PHY_INIT as the current cycle and dfi_init_complete already 1
    task automatic run_seq(input bit drop_in_xpr, input bit stop_at_mrs1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rst_hold_reset_n", reset_n, 2'b00);
            chk("rst_hold_cmd", cmd, cmd_pk(OP_DESEL, OP_DESEL));
            chk("rst_hold_start", start, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("cke_wait_reset_n", reset_n, 2'b11);
            chk("cke_wait_cke", cke, 2'b00);
            chk("cke_wait_cmd", cmd, cmd_pk(OP_DESEL, OP_DESEL));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("xpr_cke", cke, 2'b11);
            nop_chk("xpr");
            if (drop_in_xpr && i == 1) cmp = 1'b0;
        end
        issue_chk("mrs2", OP_MRS, 16'h0008, 3'd2);
        chk("b_mrs2_cmd",  b_cmd,  cmd_pk(OP_MRS, OP_NOP));
        chk("b_mrs2_bank", b_bank, bank_pk(3'd2));
        tick();
        nop_chk("mrd2_w1");
        chk("b_mrs3_cmd",  b_cmd,  cmd_pk(OP_MRS, OP_NOP));
        chk("b_mrs3_bank", b_bank, bank_pk(3'd3));
        chk("b_mrs3_addr", b_addr, addr_pk(16'h0000));
        tick();
        nop_chk("mrd2_w2");
        chk("b_mrs1_cmd",  b_cmd,  cmd_pk(OP_MRS, OP_NOP));
        chk("b_mrs1_bank", b_bank, bank_pk(3'd1));
        chk("b_mrs1_addr", b_addr, addr_pk(16'h0044));
        tick();
        nop_chk("mrd2_w3");
        chk("b_mrs0_cmd",  b_cmd,  cmd_pk(OP_MRS, OP_NOP));
        chk("b_mrs0_bank", b_bank, bank_pk(3'd0));
        chk("b_mrs0_addr", b_addr, addr_pk(16'h0520));
        issue_chk("mrs3", OP_MRS, 16'h0000, 3'd3);
        nop_cycles("mrd3", 3);
        issue_chk("mrs1", OP_MRS, 16'h0044, 3'd1);
        if (stop_at_mrs1) return;
        nop_cycles("mrd1", 3);
        issue_chk("mrs0", OP_MRS, 16'h0520, 3'd0);
        nop_cycles("mod", 5);
        issue_chk("zqcl", OP_ZQCL, 16'h0400, 3'd0);
        chk("zqcl_busy", busy, 1'b1);
        chk("b_done_before", b_done, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick();
            nop_chk("zqinit");
            chk("zqinit_done", done, 1'b0);
            if (i == 0) chk("b_done_after", b_done, 1'b1);
        end
        tick();
        chk("done_done",  done,  1'b1);
        chk("done_busy",  busy,  1'b0);
        chk("done_start", start, 1'b1);
        chk("done_cmd",   cmd,   cmd_pk(OP_NOP, OP_NOP));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_sticky", done, 1'b1);
            chk("done_idle_cmd", cmd, cmd_pk(OP_NOP, OP_NOP));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        // Run 1: PHY holds off for 20 cycles, complete drops during XPR
        rst = 1'b1;
        cmp = 1'b0;
        repeat (3) tick();
        chk_reset("por");
        rst = 1'b0;
        tick();
        chk("phy_start", start, 1'b1);
        chk("phy_busy", busy, 1'b1);
        chk("phy_reset_n", reset_n, 2'b00);
        for (int i = 0; i < 19; i++) begin
            tick();
            chk("phy_wait_start", start, 1'b1);
            chk("phy_wait_reset_n", reset_n, 2'b00);
        end
        cmp = 1'b1;
        run_seq(1'b1, 1'b0);

        // Run 2: complete already high at PHY_INIT, reset during MRS1
        cmp = 1'b1;
        rst = 1'b1;
        #1;
        chk_reset("rerun_async");
        tick();
        rst = 1'b0;
        tick();
        chk("phy2_start", start, 1'b1);
        run_seq(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk_reset("mrs1_async");
        tick();
        chk_reset("mrs1_edge");

        // Run 3: restart after mid-sequence reset completes with same timing
        rst = 1'b0;
        tick();
        chk("phy3_start", start, 1'b1);
        chk("phy3_busy", busy, 1'b1);
        run_seq(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
